// File: rtl/fft_power_framer.sv
// ---------------------------------------------------------------------------------------------
// fft_power_framer
//
// Upstream stage of the formant estimator. Converts complex FFT beats to per-bin power |X|^2,
// buffers bins 0..I-1 of one frame, and replays them as one contiguous burst of exactly I
// fft_valid cycles once the consumer reports idle. Frames that arrive while a buffered frame
// is pending or being replayed are discarded, and frame_dropped pulses for each one.
//
// Optional feature macro: FFT_POWER_PEAK_EN
//   When defined, adds peak_bin / peak_power outputs that report the strongest bin of the most
//   recently accepted frame (ties keep the lower bin).
//
// Ports
//   clk_in        in   system clock
//   rst_in        in   synchronous active-high reset
//   fft_tdata     in   {imag, real}, both signed IN_WIDTH
//   fft_tvalid    in   input beat valid (no backpressure)
//   fft_tlast     in   last beat of an FFT frame
//   out_ready     in   consumer idle, a burst may start
//   fft_valid     out  high for exactly I consecutive cycles per emitted frame
//   fft_data      out  power of bin k on the k-th fft_valid cycle, 0 otherwise
//   frame_dropped out  one-cycle pulse for each discarded frame
//   busy          out  a frame is buffered (HOLD) or being replayed (EMIT)
//   peak_bin      out  (FFT_POWER_PEAK_EN) bin index of the maximum power
//   peak_power    out  (FFT_POWER_PEAK_EN) maximum saturated power
// ---------------------------------------------------------------------------------------------
module fft_power_framer #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned I         = 160,
    parameter int unsigned FFT_SIZE  = 1024,
    parameter int unsigned SHIFT     = 0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [2*IN_WIDTH-1:0]   fft_tdata,
    input  logic                    fft_tvalid,
    input  logic                    fft_tlast,
    input  logic                    out_ready,
    output logic                    fft_valid,
    output logic [BIT_WIDTH-1:0]    fft_data,
    output logic                    frame_dropped,
`ifdef FFT_POWER_PEAK_EN
    output logic                    busy,
    output logic [$clog2(I)-1:0]    peak_bin,
    output logic [BIT_WIDTH-1:0]    peak_power
`else
    output logic                    busy
`endif
);

    localparam int unsigned AW   = $clog2(I);
    localparam int unsigned CW   = $clog2(FFT_SIZE);
    localparam int unsigned PW   = 2 * IN_WIDTH;
    localparam int unsigned SumW = PW + 1;
    localparam int unsigned ExtW = (BIT_WIDTH > SumW) ? BIT_WIDTH : SumW;

    localparam logic [CW-1:0] CntMax = CW'(FFT_SIZE - 1);
    localparam logic [CW-1:0] BinLast = CW'(I - 1);
    localparam logic [AW-1:0] RdLast = AW'(I - 1);

    typedef enum logic [2:0] {
        StSync,
        StCapture,
        StDrain,
        StHold,
        StEmit
    } state_e;

    // ------------------------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             drain_q, drain_d;
    logic [AW-1:0]          rd_cnt_q, rd_cnt_d;

    logic [PW-1:0]          s1_re_q, s1_re_d;
    logic [PW-1:0]          s1_im_q, s1_im_d;
    logic [AW-1:0]          s1_bin_q, s1_bin_d;
    logic                   s1_vld_q, s1_vld_d;

    logic [BIT_WIDTH-1:0]   s2_pow_q, s2_pow_d;
    logic [AW-1:0]          s2_bin_q, s2_bin_d;
    logic                   s2_vld_q, s2_vld_d;

    logic                   rd_vld_q, rd_vld_d;
    logic                   out_vld_q, out_vld_d;
    logic [BIT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   drop_q, drop_d;
    logic                   busy_q, busy_d;

    logic [BIT_WIDTH-1:0]   mem [I];
    logic [BIT_WIDTH-1:0]   ram_rd_q;

    logic                   tlast_vld;
    logic                   rd_en;

    logic signed [IN_WIDTH-1:0] re_in;
    logic signed [IN_WIDTH-1:0] im_in;
    logic signed [PW-1:0]       re_sq;
    logic signed [PW-1:0]       im_sq;
    logic [SumW-1:0]            pow_sum;
    logic [SumW-1:0]            pow_shifted;
    logic [ExtW-1:0]            pow_ext;

    assign tlast_vld = fft_tvalid & fft_tlast;
    assign rd_en     = (state_q == StEmit);

    assign re_in = fft_tdata[IN_WIDTH-1:0];
    assign im_in = fft_tdata[PW-1:IN_WIDTH];
    assign re_sq = re_in * re_in;
    assign im_sq = im_in * im_in;

    // ------------------------------------------------------------------------------------------
    // Bin counter: clears on tlast, saturates rather than wrapping on oversize frames
    // ------------------------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (fft_tvalid) begin
            if (fft_tlast) begin
                cnt_d = '0;
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Power pipe. The capture decision is made on entry so late pipe contents cannot leak into
    // the buffer once the FSM has left CAPTURE.
    // ------------------------------------------------------------------------------------------
    always_comb begin
        s1_re_d  = $unsigned(re_sq);
        s1_im_d  = $unsigned(im_sq);
        s1_bin_d = cnt_q[AW-1:0];
        s1_vld_d = fft_tvalid && (state_q == StCapture) && (cnt_q <= BinLast);

        pow_sum     = {1'b0, s1_re_q} + {1'b0, s1_im_q};
        pow_shifted = pow_sum >> SHIFT;
        pow_ext     = ExtW'(pow_shifted);
        // Any set bit above the output width saturates to all ones.
        s2_pow_d    = ((pow_ext >> BIT_WIDTH) != '0) ? '1 : pow_ext[BIT_WIDTH-1:0];
        s2_bin_d    = s1_bin_q;
        s2_vld_d    = s1_vld_q;
    end

    // ------------------------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        rd_cnt_d = rd_cnt_q;
        drop_d   = 1'b0;

        case (state_q)
            StSync: begin
                if (tlast_vld) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (tlast_vld) begin
                    if (cnt_q >= BinLast) begin
                        state_d = StDrain;
                        drain_d = 2'd2;
                    end else begin
                        // Short frame: buffer contents are incomplete, start over at next beat.
                        drop_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                // Waits for the final bins to clear the power pipe into the buffer.
                if (tlast_vld) begin
                    drop_d = 1'b1;
                end
                if (drain_q == 2'd0) begin
                    state_d = StHold;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            StHold: begin
                if (tlast_vld) begin
                    drop_d = 1'b1;
                end
                if (out_ready) begin
                    state_d  = StEmit;
                    rd_cnt_d = '0;
                end
            end
            StEmit: begin
                if (rd_cnt_q == RdLast) begin
                    // A tlast on the final read is the sync event for the next capture.
                    state_d = tlast_vld ? StCapture : StSync;
                end else begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                    if (tlast_vld) begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StSync;
            end
        endcase

        busy_d = (state_d == StHold) || (state_d == StEmit);
    end

    // ------------------------------------------------------------------------------------------
    // Output stage: read data arrives one cycle after the read, then is registered once more
    // ------------------------------------------------------------------------------------------
    always_comb begin
        rd_vld_d   = rd_en;
        out_vld_d  = rd_vld_q;
        out_data_d = rd_vld_q ? ram_rd_q : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StSync;
            cnt_q      <= '0;
            drain_q    <= '0;
            rd_cnt_q   <= '0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_bin_q   <= '0;
            s1_vld_q   <= 1'b0;
            s2_pow_q   <= '0;
            s2_bin_q   <= '0;
            s2_vld_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            rd_cnt_q   <= rd_cnt_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s1_bin_q   <= s1_bin_d;
            s1_vld_q   <= s1_vld_d;
            s2_pow_q   <= s2_pow_d;
            s2_bin_q   <= s2_bin_d;
            s2_vld_q   <= s2_vld_d;
            rd_vld_q   <= rd_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
        end
    end

    // Frame buffer: one write port fed by the pipe, one registered read port.
    always_ff @(posedge clk_in) begin
        if (s2_vld_q) begin
            mem[s2_bin_q] <= s2_pow_q;
        end
        if (rd_en) begin
            ram_rd_q <= mem[rd_cnt_q];
        end
    end

    assign fft_valid     = out_vld_q;
    assign fft_data      = out_data_q;
    assign frame_dropped = drop_q;
    assign busy          = busy_q;

`ifdef FFT_POWER_PEAK_EN
    // ------------------------------------------------------------------------------------------
    // Peak tracker: running max over written bins, published only when a frame is accepted
    // ------------------------------------------------------------------------------------------
    logic [AW-1:0]        run_bin_q, run_bin_d;
    logic [BIT_WIDTH-1:0] run_pow_q, run_pow_d;
    logic [AW-1:0]        peak_bin_q, peak_bin_d;
    logic [BIT_WIDTH-1:0] peak_pow_q, peak_pow_d;

    always_comb begin
        run_bin_d  = run_bin_q;
        run_pow_d  = run_pow_q;
        peak_bin_d = peak_bin_q;
        peak_pow_d = peak_pow_q;
        // Bins arrive in ascending order, so a strict compare keeps the lower bin on ties.
        if (s2_vld_q && ((s2_bin_q == '0) || (s2_pow_q > run_pow_q))) begin
            run_bin_d = s2_bin_q;
            run_pow_d = s2_pow_q;
        end
        if ((state_q == StDrain) && (state_d == StHold)) begin
            peak_bin_d = run_bin_d;
            peak_pow_d = run_pow_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            run_bin_q  <= '0;
            run_pow_q  <= '0;
            peak_bin_q <= '0;
            peak_pow_q <= '0;
        end else begin
            run_bin_q  <= run_bin_d;
            run_pow_q  <= run_pow_d;
            peak_bin_q <= peak_bin_d;
            peak_pow_q <= peak_pow_d;
        end
    end

    assign peak_bin   = peak_bin_q;
    assign peak_power = peak_pow_q;
`endif

endmodule

// File: tb/tb_fft_power_framer.sv
// ---------------------------------------------------------------------------------------------
// tb_fft_power_framer
//
// Directed bench for fft_power_framer. Two instances share one input stream: the default
// 32-bit output build and a 24-bit output build for the saturation case. Expected powers are
// computed from the stimulus pattern by a small reference function.
// ---------------------------------------------------------------------------------------------
module tb_fft_power_framer;

    localparam int NB = 160;

    logic        clk;
    logic        rst_in;
    logic [31:0] fft_tdata;
    logic        fft_tvalid;
    logic        fft_tlast;
    logic        out_ready;

    logic        fft_valid;
    logic [31:0] fft_data;
    logic        frame_dropped;
    logic        busy;
    logic        fft_valid24;
    logic [23:0] fft_data24;
    logic        frame_dropped24;
    logic        busy24;
`ifdef FFT_POWER_PEAK_EN
    logic [7:0]  peak_bin;
    logic [31:0] peak_power;
    logic [7:0]  peak_bin24;
    logic [23:0] peak_power24;
`endif

    fft_power_framer dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .fft_tdata     (fft_tdata),
        .fft_tvalid    (fft_tvalid),
        .fft_tlast     (fft_tlast),
        .out_ready     (out_ready),
        .fft_valid     (fft_valid),
        .fft_data      (fft_data),
        .frame_dropped (frame_dropped),
`ifdef FFT_POWER_PEAK_EN
        .busy          (busy),
        .peak_bin      (peak_bin),
        .peak_power    (peak_power)
`else
        .busy          (busy)
`endif
    );

    fft_power_framer #(.BIT_WIDTH(24)) dut24 (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .fft_tdata     (fft_tdata),
        .fft_tvalid    (fft_tvalid),
        .fft_tlast     (fft_tlast),
        .out_ready     (out_ready),
        .fft_valid     (fft_valid24),
        .fft_data      (fft_data24),
        .frame_dropped (frame_dropped24),
`ifdef FFT_POWER_PEAK_EN
        .busy          (busy24),
        .peak_bin      (peak_bin24),
        .peak_power    (peak_power24)
`else
        .busy          (busy24)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus patterns: 0 junk, 1 re=k, 2 full-scale negative, 3 peak test, 4 re=k+1 im=-k
    function automatic int re_of(input int pat, input int k);
        case (pat)
            0: return ((k * 37) % 2000) - 1000;
            1: return k;
            2: return -32768;
            3: return (k == 37) ? 30 : ((k == 80) ? 0 : 1);
            default: return k + 1;
        endcase
    endfunction

    function automatic int im_of(input int pat, input int k);
        case (pat)
            0: return k % 50;
            1: return 0;
            2: return -32768;
            3: return (k == 80) ? 30 : 0;
            default: return -k;
        endcase
    endfunction

    function automatic logic [63:0] exp_pow(input int pat, input int k, input int bw);
        longint r, m, p, lim;
        r   = re_of(pat, k);
        m   = im_of(pat, k);
        p   = r * r + m * m;
        lim = (longint'(1) << bw) - 1;
        return (p > lim) ? lim : p;
    endfunction

    function automatic logic [31:0] beat(input int pat, input int k);
        int r, m;
        r = re_of(pat, k);
        m = im_of(pat, k);
        return {m[15:0], r[15:0]};
    endfunction

    // Output monitor, sampled on the falling edge.
    int          cur_len = 0;
    int          last_len = 0;
    int          bursts = 0;
    int          drops = 0;
    int          zero_viol = 0;
    int          lockstep_viol = 0;
    logic [31:0] obuf [NB];
    logic [23:0] obuf24 [NB];

    initial begin
        forever begin
            @(negedge clk);
            if (fft_valid) begin
                if (cur_len < NB) begin
                    obuf[cur_len]   = fft_data;
                    obuf24[cur_len] = fft_data24;
                end
                cur_len++;
            end else if (cur_len != 0) begin
                last_len = cur_len;
                bursts++;
                cur_len = 0;
            end
            if (frame_dropped) drops++;
            if (!fft_valid && fft_data != 32'd0) zero_viol++;
            if (fft_valid !== fft_valid24) lockstep_viol++;
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input int pat, input int len);
        for (int b = 0; b < len; b++) begin
            fft_tdata  = beat(pat, b);
            fft_tvalid = 1'b1;
            fft_tlast  = (b == len - 1);
            tick(1);
        end
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
        fft_tdata  = '0;
    endtask

    task automatic wait_bursts(input string tag, input int target);
        int n;
        n = 0;
        while (bursts < target && n < 2000) begin
            tick(1);
            n++;
        end
        check_eq(tag, bursts, target);
    endtask

    task automatic check_burst(input string tag, input int pat);
        check_eq({tag, "_len"}, last_len, NB);
        for (int k = 0; k < NB; k++) begin
            check_eq($sformatf("%s_bin%0d", tag, k), obuf[k], exp_pow(pat, k, 32));
        end
    endtask

    int d0, b0, n;

    initial begin
        rst_in     = 1'b1;
        fft_tdata  = '0;
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
        out_ready  = 1'b0;
        tick(3);
        check_eq("rst_valid", fft_valid, 0);
        check_eq("rst_data", fft_data, 0);
        check_eq("rst_drop", frame_dropped, 0);
        check_eq("rst_busy", busy, 0);
        rst_in = 1'b0;
        tick(2);

        // 1: junk sync frame, then a ramp frame
        out_ready = 1'b1;
        drive_frame(0, 1024);
        drive_frame(1, 1024);
        wait_bursts("t1_burst", 1);
        check_burst("t1", 1);
        check_eq("t1_bin159_24", obuf24[159], exp_pow(1, 159, 24));
        check_eq("t1_drops", drops, 0);
        tick(5);

        // 2: full-scale negative input, 32-bit exact vs 24-bit saturated
        drive_frame(0, 1);
        drive_frame(2, 1024);
        wait_bursts("t2_burst", 2);
        check_burst("t2", 2);
        check_eq("t2_bin0_24", obuf24[0], 24'hFFFFFF);
        check_eq("t2_bin159_24", obuf24[159], 24'hFFFFFF);
        check_eq("t2_drops", drops, 0);
        tick(5);

        // 3: consumer busy across three frames, then release
        out_ready = 1'b0;
        d0 = drops;
        drive_frame(0, 1);
        drive_frame(4, 1024);
        for (int f = 0; f < 3; f++) drive_frame(1, 1024);
        tick(5);
        check_eq("t3_busy", busy, 1);
        check_eq("t3_drops", drops - d0, 3);
        check_eq("t3_no_burst", bursts, 2);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;           // must not pause the burst already started
        wait_bursts("t3_burst", 3);
        check_burst("t3", 4);
        tick(5);
        check_eq("t3_idle", busy, 0);

        // 4: short frame during capture, then a full frame
        out_ready = 1'b1;
        d0 = drops;
        drive_frame(0, 1);
        drive_frame(1, 101);
        tick(20);
        check_eq("t4_drop", drops - d0, 1);
        check_eq("t4_no_burst", bursts, 3);
        drive_frame(4, 1024);
        wait_bursts("t4_burst", 4);
        check_burst("t4", 4);
        check_eq("t4_drops_after", drops - d0, 1);
        tick(5);

        // 5: reset on the 50th output cycle
        drive_frame(0, 1);
        drive_frame(1, 1024);
        n = 0;
        for (int c = 0; c < 400 && n < 50; c++) begin
            tick(1);
            if (fft_valid) n++;
        end
        check_eq("t5_reached50", n, 50);
        rst_in = 1'b1;
        tick(1);
        check_eq("t5_valid_cut", fft_valid, 0);
        check_eq("t5_busy_cut", busy, 0);
        rst_in = 1'b0;
        tick(3);
        check_eq("t5_trunc_len", last_len, 50);
        b0 = bursts;
        drive_frame(4, 1024);       // only a sync frame after reset
        tick(200);
        check_eq("t5_no_burst", bursts, b0);
        drive_frame(4, 1024);
        wait_bursts("t5_burst", b0 + 1);
        check_burst("t5", 4);
        tick(5);

`ifdef FFT_POWER_PEAK_EN
        // 6: peak tracking, reported on entry to HOLD
        out_ready = 1'b0;
        b0 = bursts;
        drive_frame(0, 1);
        drive_frame(3, 1024);
        n = 0;
        while (!busy && n < 50) begin
            tick(1);
            n++;
        end
        check_eq("t6_busy", busy, 1);
        check_eq("t6_peak_bin", peak_bin, 37);
        check_eq("t6_peak_power", peak_power, 900);
        out_ready = 1'b1;
        wait_bursts("t6_burst", b0 + 1);
        check_eq("t6_bin37", obuf[37], 900);
        check_eq("t6_peak_hold", peak_bin, 37);
`endif

        check_eq("data_zero_when_idle", zero_viol, 0);
        check_eq("lockstep_24", lockstep_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
